// File: rtl/plab2_proc_fetch_unit.sv
// Instruction-fetch front-end: PC generation, multi-outstanding imem requests, counted
// response dropping after redirects and a decoupling FIFO. Optional macro: PLAB2_PROC_FETCH_BYPASS_EN.
module plab2_proc_fetch_unit #(
  parameter int unsigned p_buf_depth    = 4,
  parameter int unsigned p_max_out      = 2,
  parameter logic [31:0] c_reset_vector = 32'h1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        domain,
  input  logic        redirect_val,
  input  logic [31:0] redirect_pc,
  output logic [77:0] imemreq_msg,
  output logic        imemreq_val,
  input  logic        imemreq_rdy,
  input  logic [46:0] imemresp_msg,
  input  logic        imemresp_val,
  output logic        imemresp_rdy,
  output logic [31:0] inst_msg,
  output logic [31:0] inst_pc,
  output logic        inst_val,
  input  logic        inst_rdy
);

  localparam int unsigned CntW = $clog2(p_buf_depth + 1);
  localparam int unsigned PtrW = $clog2(p_buf_depth);
  localparam logic [CntW-1:0] MaxOut   = CntW'(p_max_out);
  localparam logic [CntW:0]   DepthCap = (CntW + 1)'(p_buf_depth);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(p_buf_depth - 1);

  logic [31:0]     req_pc_q, req_pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic [CntW-1:0] out_cnt_q, out_cnt_d;
  logic [CntW-1:0] buf_cnt_q, buf_cnt_d;
  logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [31:0]     buf_pc_q   [p_buf_depth];
  logic [31:0]     buf_data_q [p_buf_depth];

  logic        req_fire, resp_fire, resp_keep, buf_empty, push, pop, bypass;
  logic [31:0] resp_data;
  logic        unused_resp;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  // Memory message layout: {domain, type, opaque, addr, len, data}; READ is type 0.
  assign imemreq_msg = {domain, 3'd0, 8'd0, req_pc_q, 2'd0, 32'd0};
  assign resp_data   = imemresp_msg[31:0];
  assign unused_resp = ^imemresp_msg[46:32];

  // Credit rule: in-flight plus buffered never exceeds the buffer, so responses always fit.
  assign imemreq_val  = !reset && (out_cnt_q < MaxOut) &&
                        (({1'b0, out_cnt_q} + {1'b0, buf_cnt_q}) < DepthCap);
  assign imemresp_rdy = !reset;

  assign req_fire  = imemreq_val && imemreq_rdy;
  assign resp_fire = imemresp_val && imemresp_rdy;
  assign resp_keep = resp_fire && (drop_cnt_q == '0) && !redirect_val;
  assign buf_empty = (buf_cnt_q == '0);

`ifdef PLAB2_PROC_FETCH_BYPASS_EN
  assign bypass   = resp_keep && buf_empty;
  assign inst_val = !reset && (!buf_empty || bypass);
  assign inst_pc  = buf_empty ? resp_pc_q : buf_pc_q[head_q];
  assign inst_msg = buf_empty ? resp_data : buf_data_q[head_q];
  assign push     = resp_keep && !(bypass && inst_rdy);
`else
  assign bypass   = 1'b0;
  assign inst_val = !reset && !buf_empty;
  assign inst_pc  = buf_pc_q[head_q];
  assign inst_msg = buf_data_q[head_q];
  assign push     = resp_keep;
`endif

  assign pop = !reset && !buf_empty && inst_rdy;

  always_comb begin
    req_pc_d   = req_pc_q;
    resp_pc_d  = resp_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    out_cnt_d  = out_cnt_q + CntW'(req_fire) - CntW'(resp_fire);
    buf_cnt_d  = buf_cnt_q + CntW'(push) - CntW'(pop);
    drop_cnt_d = drop_cnt_q;

    if (req_fire)  req_pc_d  = req_pc_q + 32'd4;
    if (resp_keep) resp_pc_d = resp_pc_q + 32'd4;
    if (push)      tail_d    = ptr_inc(tail_q);
    if (pop)       head_d    = ptr_inc(head_q);
    if (resp_fire && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CntW'(1);

    // Everything still in flight after this cycle belongs to the old path.
    if (redirect_val) begin
      req_pc_d   = redirect_pc;
      resp_pc_d  = redirect_pc;
      head_d     = '0;
      tail_d     = '0;
      buf_cnt_d  = '0;
      drop_cnt_d = out_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_pc_q   <= c_reset_vector;
      resp_pc_q  <= c_reset_vector;
      out_cnt_q  <= '0;
      buf_cnt_q  <= '0;
      drop_cnt_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      req_pc_q   <= req_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_cnt_q  <= out_cnt_d;
      buf_cnt_q  <= buf_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc_q[tail_q]   <= resp_pc_q;
      buf_data_q[tail_q] <= resp_data;
    end
  end

endmodule
